csr_unit: RTL and testbench

Parametrised successor to the single-op CSR decoder. It decodes all six Zicsr ops (CSRRW/S/C and their immediate forms) and owns the architectural counter and scratch state. Sits beside the ALU in the single-cycle datapath, fed from the instruction fields and rs1. It returns the old CSR value for rd and commits the write at the clock edge.

---
 rtl/csr_unit.sv | 139 +++++++++++++
 tb/tb_csr_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Zicsr decoder and architectural CSR state (cycle/time, instret, mscratch).
// Optional mcountinhibit at 0x320 is built when CSR_COUNTER_INHIBIT_EN is defined.
module csr_unit #(
    parameter int          XLEN           = 32,
    parameter int          COUNTER_WIDTH  = 64,
    parameter logic [31:0] MSCRATCH_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            csr_valid,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            instr_retired,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal
);

    localparam int HI_W = COUNTER_WIDTH - 32;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] cycle_q;
    logic [COUNTER_WIDTH-1:0] instret_q;
    logic [XLEN-1:0]          mscratch_q;
    logic [63:0]              cycle_ext;
    logic [63:0]              instret_ext;
    logic [XLEN-1:0]          operand;
    logic [XLEN-1:0]          old_val;
    logic [XLEN-1:0]          new_val;
    logic                     op_ok;
    logic                     wr_req;
    logic                     mapped;
    logic                     read_only;
    logic                     do_write;
    logic                     cy_run;
    logic                     ir_run;
    logic                     wr_mcycle_lo;
    logic                     wr_mcycle_hi;
    logic                     wr_minstret_lo;
    logic                     wr_minstret_hi;
    logic                     wr_mscratch;

`ifdef CSR_COUNTER_INHIBIT_EN
    logic                     cy_inhibit_q;
    logic                     ir_inhibit_q;
    logic                     wr_inhibit;
`endif

    // High-half reads zero-extend counters narrower than 64 bits.
    assign cycle_ext   = 64'(cycle_q);
    assign instret_ext = 64'(instret_q);

    always_comb begin
        op_ok     = funct3[1:0] != 2'b00;
        operand   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
        wr_req    = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        mapped    = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (csr_addr)
            12'hC00, 12'hC01: begin old_val = cycle_ext[31:0];    read_only = 1'b1; end
            12'hC80, 12'hC81: begin old_val = cycle_ext[63:32];   read_only = 1'b1; end
            12'hC02:          begin old_val = instret_ext[31:0];  read_only = 1'b1; end
            12'hC82:          begin old_val = instret_ext[63:32]; read_only = 1'b1; end
            12'hB00:          old_val = cycle_ext[31:0];
            12'hB80:          old_val = cycle_ext[63:32];
            12'hB02:          old_val = instret_ext[31:0];
            12'hB82:          old_val = instret_ext[63:32];
            12'h340:          old_val = mscratch_q;
`ifdef CSR_COUNTER_INHIBIT_EN
            12'h320:          old_val = {29'd0, ir_inhibit_q, 1'b0, cy_inhibit_q};
`endif
            default:          mapped = 1'b0;
        endcase

        csr_illegal = csr_valid && (!op_ok || !mapped || (read_only && wr_req));
        csr_rdata   = (csr_valid && !csr_illegal) ? old_val : '0;

        case (funct3[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_val | operand;
            default: new_val = old_val & ~operand;
        endcase
        do_write = csr_valid && !csr_illegal && wr_req;
    end

    assign wr_mcycle_lo   = do_write && (csr_addr == 12'hB00);
    assign wr_mcycle_hi   = do_write && (csr_addr == 12'hB80);
    assign wr_minstret_lo = do_write && (csr_addr == 12'hB02);
    assign wr_minstret_hi = do_write && (csr_addr == 12'hB82);
    assign wr_mscratch    = do_write && (csr_addr == 12'h340);

`ifdef CSR_COUNTER_INHIBIT_EN
    assign wr_inhibit = do_write && (csr_addr == 12'h320);
    assign cy_run     = !cy_inhibit_q;
    assign ir_run     = !ir_inhibit_q && instr_retired;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cy_inhibit_q <= 1'b0;
            ir_inhibit_q <= 1'b0;
        end else if (wr_inhibit) begin
            cy_inhibit_q <= new_val[0];
            ir_inhibit_q <= new_val[2];
        end
    end
`else
    assign cy_run = 1'b1;
    assign ir_run = instr_retired;
`endif

    // An explicit write to either half replaces that half and suppresses the increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_q    <= '0;
            instret_q  <= '0;
            mscratch_q <= MSCRATCH_RESET;
        end else begin
            if (wr_mcycle_lo)
                cycle_q[31:0] <= new_val;
            else if (wr_mcycle_hi)
                cycle_q[COUNTER_WIDTH-1:32] <= new_val[HI_W-1:0];
            else if (cy_run)
                cycle_q <= cycle_q + CNT_ONE;

            if (wr_minstret_lo)
                instret_q[31:0] <= new_val;
            else if (wr_minstret_hi)
                instret_q[COUNTER_WIDTH-1:32] <= new_val[HI_W-1:0];
            else if (ir_run)
                instret_q <= instret_q + CNT_ONE;

            if (wr_mscratch)
                mscratch_q <= new_val;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: vector table plus hand sequences, checked through a queue of expectations.
module tb_csr_unit;

    localparam int CW = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_valid;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        instr_retired;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    always #5 clk = ~clk;

    csr_unit #(.XLEN(32), .COUNTER_WIDTH(CW), .MSCRATCH_RESET(32'h0)) dut (
        .clk(clk), .resetn(resetn), .csr_valid(csr_valid), .funct3(funct3),
        .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
        .instr_retired(instr_retired), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        ret;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[18];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference state kept as plain 64-bit quantities.
    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_msc, m_inh;
    logic [31:0] m_rd, m_nv;
    logic        m_ill, m_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_cyc = '0; m_ins = '0; m_msc = 32'h0; m_inh = '0;
    endtask

    task automatic model_eval();
        logic        op_ok, we, mapped, ro;
        logic [31:0] opnd, old;
        op_ok  = funct3 inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        opnd   = funct3[2] ? {27'd0, rs1_idx} : rs1_data;
        we     = (funct3 == 3'd1) || (funct3 == 3'd5) || (rs1_idx != 0);
        mapped = 1'b1; ro = 1'b0; old = '0;
        case (csr_addr)
            12'hC00, 12'hC01: begin old = m_cyc[31:0];  ro = 1'b1; end
            12'hC80, 12'hC81: begin old = m_cyc[63:32]; ro = 1'b1; end
            12'hC02:          begin old = m_ins[31:0];  ro = 1'b1; end
            12'hC82:          begin old = m_ins[63:32]; ro = 1'b1; end
            12'hB00: old = m_cyc[31:0];
            12'hB80: old = m_cyc[63:32];
            12'hB02: old = m_ins[31:0];
            12'hB82: old = m_ins[63:32];
            12'h340: old = m_msc;
`ifdef CSR_COUNTER_INHIBIT_EN
            12'h320: old = m_inh;
`endif
            default: mapped = 1'b0;
        endcase
        m_ill = csr_valid && (!op_ok || !mapped || (ro && we));
        m_rd  = (csr_valid && !m_ill) ? old : 32'h0;
        case (funct3)
            3'd1, 3'd5: m_nv = opnd;
            3'd2, 3'd6: m_nv = old | opnd;
            default:    m_nv = old & ~opnd;
        endcase
        m_wr = csr_valid && !m_ill && we;
    endtask

    task automatic model_commit();
        logic [63:0] cn, in;
        cn = m_cyc; in = m_ins;
        if (m_wr && csr_addr == 12'hB00)      cn[31:0]  = m_nv;
        else if (m_wr && csr_addr == 12'hB80) cn[63:32] = m_nv;
        else if (!m_inh[0])                   cn = m_cyc + 64'd1;
        if (m_wr && csr_addr == 12'hB02)      in[31:0]  = m_nv;
        else if (m_wr && csr_addr == 12'hB82) in[63:32] = m_nv;
        else if (!m_inh[2] && instr_retired)  in = m_ins + 64'd1;
        if (m_wr && csr_addr == 12'h340) m_msc = m_nv;
        if (m_wr && csr_addr == 12'h320) m_inh = m_nv & 32'h5;
        m_cyc = cn; m_ins = in;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [11:0] a,
                         input logic [4:0] idx, input logic [31:0] d, input logic r);
        csr_valid = v; funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d; instr_retired = r;
    endtask

    task automatic expect_val(input string name, input logic [31:0] rd, input logic ill);
        exp_q.push_back('{name, rd, ill});
    endtask

    task automatic expect_model(input string name);
        model_eval();
        exp_q.push_back('{name, m_rd, m_ill});
    endtask

    task automatic compare_pending();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_rdata"}, csr_rdata, e.rd);
            check({e.name, "_illegal"}, {31'd0, csr_illegal}, {31'd0, e.ill});
        end
    endtask

    task automatic finish_cycle();
        @(negedge clk);
        compare_pending();
        if (resetn) begin
            model_eval();
            model_commit();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 3'd0, 12'h000, 5'd0, 32'h0, r);
        finish_cycle();
    endtask

    initial begin
        tbl[0]  = '{"msc_rw",      1'b1, 3'd1, 12'h340, 5'd5, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
        tbl[1]  = '{"msc_rc",      1'b1, 3'd3, 12'h340, 5'd6, 32'h0000FFFF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{"msc_rd_x0",   1'b1, 3'd2, 12'h340, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hDEAD0000, 1'b0};
        tbl[3]  = '{"msc_rsi",     1'b1, 3'd6, 12'h340, 5'd3, 32'h0,        1'b0, 32'hDEAD0000, 1'b0};
        tbl[4]  = '{"msc_rci",     1'b1, 3'd7, 12'h340, 5'd1, 32'h0,        1'b0, 32'hDEAD0003, 1'b0};
        tbl[5]  = '{"msc_rd2",     1'b1, 3'd2, 12'h340, 5'd0, 32'h0,        1'b0, 32'hDEAD0002, 1'b0};
        tbl[6]  = '{"ro_write",    1'b1, 3'd1, 12'hC00, 5'd5, 32'h1,        1'b0, 32'h0,        1'b1};
        tbl[7]  = '{"ro_set",      1'b1, 3'd2, 12'hC02, 5'd1, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[8]  = '{"f3_000",      1'b1, 3'd0, 12'h340, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[9]  = '{"f3_100",      1'b1, 3'd4, 12'h340, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[10] = '{"unmapped",    1'b1, 3'd2, 12'h123, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[11] = '{"unmapped_w",  1'b1, 3'd1, 12'h341, 5'd2, 32'h55,       1'b0, 32'h0,        1'b1};
        tbl[12] = '{"no_valid",    1'b0, 3'd1, 12'h340, 5'd3, 32'h1234,     1'b1, 32'h0,        1'b0};
        tbl[13] = '{"ro_hi_clr",   1'b1, 3'd7, 12'hC80, 5'd4, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[14] = '{"msc_kept",    1'b1, 3'd2, 12'h340, 5'd0, 32'h0,        1'b0, 32'hDEAD0002, 1'b0};
`ifdef CSR_COUNTER_INHIBIT_EN
        tbl[15] = '{"inh_access",  1'b1, 3'd2, 12'h320, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};
`else
        tbl[15] = '{"inh_access",  1'b1, 3'd2, 12'h320, 5'd0, 32'h0,        1'b0, 32'h0,        1'b1};
`endif
        tbl[16] = '{"msc_rwi0",    1'b1, 3'd5, 12'h340, 5'd0, 32'hFFFF,     1'b0, 32'hDEAD0002, 1'b0};
        tbl[17] = '{"msc_zero",    1'b1, 3'd2, 12'h340, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0};

        model_reset();
        drive(1'b0, 3'd0, 12'h000, 5'd0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b1);
        expect_val("rst_cycle", 32'h0, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'h340, 5'd0, 32'h0, 1'b0);
        expect_val("rst_mscratch", 32'h0, 1'b0);
        finish_cycle();
        drive(1'b0, 3'd0, 12'h340, 5'd0, 32'h0, 1'b0);
        expect_val("rst_idle", 32'h0, 1'b0);
        finish_cycle();
        resetn = 1'b1;

        repeat (10) idle(1'b0);
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("cycle_after_10", 32'd10, 1'b0);
        finish_cycle();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].valid, tbl[i].f3, tbl[i].addr, tbl[i].idx, tbl[i].data, tbl[i].ret);
            expect_val(tbl[i].name, tbl[i].exp_rd, tbl[i].exp_ill);
            finish_cycle();
        end

        // Pure read with rs1_idx=0, and a rejected write to read-only cycle
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'hFF, 1'b0);
        expect_model("cycle_rs_x0");
        finish_cycle();
        drive(1'b1, 3'd1, 12'hC00, 5'd5, 32'h0, 1'b0);
        expect_model("cycle_rw_ill");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC01, 5'd0, 32'h0, 1'b0);
        expect_model("time_alias");
        finish_cycle();

        // Low write then high write: carry into high happens only afterwards
        drive(1'b1, 3'd1, 12'hB00, 5'd1, 32'hFFFFFFFF, 1'b0);
        expect_model("mcycle_wr");
        finish_cycle();
        drive(1'b1, 3'd1, 12'hB80, 5'd1, 32'h0, 1'b0);
        expect_model("mcycleh_wr");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("cyc_held", 32'hFFFFFFFF, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC80, 5'd0, 32'h0, 1'b0);
        expect_val("cych_carry", 32'h1, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("cyc_after_carry", 32'h1, 1'b0);
        finish_cycle();

        // Write beats retire increment
        drive(1'b1, 3'd5, 12'hB02, 5'd5, 32'h0, 1'b1);
        expect_model("minstret_rwi");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hB02, 5'd0, 32'h0, 1'b1);
        expect_val("minstret_5", 32'd5, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC02, 5'd0, 32'h0, 1'b0);
        expect_val("instret_6", 32'd6, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd1, 12'hB82, 5'd1, 32'h7, 1'b1);
        expect_model("minstreth_wr");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC82, 5'd0, 32'h0, 1'b0);
        expect_val("instreth_7", 32'd7, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC02, 5'd0, 32'h0, 1'b0);
        expect_val("instret_lo_held", 32'd6, 1'b0);
        finish_cycle();

        // Full 64-bit wrap
        drive(1'b1, 3'd1, 12'hB80, 5'd1, 32'hFFFFFFFF, 1'b0);
        expect_model("wrap_hi_wr");
        finish_cycle();
        drive(1'b1, 3'd1, 12'hB00, 5'd1, 32'hFFFFFFFF, 1'b0);
        expect_model("wrap_lo_wr");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("wrap_lo_max", 32'hFFFFFFFF, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC80, 5'd0, 32'h0, 1'b0);
        expect_val("wrap_hi_zero", 32'h0, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("wrap_lo_one", 32'h1, 1'b0);
        finish_cycle();

`ifdef CSR_COUNTER_INHIBIT_EN
        drive(1'b1, 3'd6, 12'h320, 5'd1, 32'h0, 1'b0);
        expect_val("inh_set", 32'h0, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_model("inh_cyc_a");
        finish_cycle();
        repeat (20) idle(1'b1);
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_model("inh_cyc_frozen");
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC02, 5'd0, 32'h0, 1'b0);
        expect_model("inh_instret_runs");
        finish_cycle();
        drive(1'b1, 3'd1, 12'h320, 5'd1, 32'hFFFFFFFF, 1'b0);
        expect_val("inh_rw", 32'h1, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd1, 12'hB00, 5'd1, 32'd100, 1'b1);
        expect_val("inh_bits", 32'h0, 1'b1);
        exp_q.delete();
        expect_model("inh_mcycle_wr");
        finish_cycle();
        drive(1'b1, 3'd2, 12'h320, 5'd0, 32'h0, 1'b0);
        expect_val("inh_readback", 32'h5, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("inh_cyc_100", 32'd100, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd7, 12'h320, 5'd5, 32'h0, 1'b0);
        expect_val("inh_clear", 32'h5, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("inh_cyc_still_100", 32'd100, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("inh_cyc_resumed", 32'd101, 1'b0);
        finish_cycle();
`endif

        // Reset asserted mid-instruction aborts the write
        drive(1'b1, 3'd1, 12'h340, 5'd1, 32'hCAFEF00D, 1'b0);
        expect_model("pre_rst_rw");
        @(negedge clk);
        compare_pending();
        resetn = 1'b0;
        #1;
        check("rst_async_rdata", csr_rdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b1, 3'd2, 12'h340, 5'd0, 32'h0, 1'b0);
        expect_val("post_rst_msc", 32'h0, 1'b0);
        finish_cycle();
        drive(1'b1, 3'd2, 12'hC00, 5'd0, 32'h0, 1'b0);
        expect_val("post_rst_cycle", 32'h1, 1'b0);
        finish_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
